// File: rtl/leaf_user_in_fifo.sv
// Elastic buffer between leaf_interface user outputs and an ap_fifo-style kernel read port.
// Optional statistics counters (word_cnt, stall_cnt) are enabled by defining LEAF_USER_IN_FIFO_STATS_EN.
module leaf_user_in_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    empty_n,
  input  logic                    rd_en,
`ifdef LEAF_USER_IN_FIFO_STATS_EN
  output logic [31:0]             word_cnt,
  output logic [31:0]             stall_cnt,
`endif
  output logic [DEPTH_BITS:0]     count
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam int CNT_W = DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic                    push;
  logic                    pop;

  // Handshake is driven purely from registered occupancy: no full or empty bypass.
  assign ack_user2interface = (count != FULL_CNT);
  assign empty_n            = (count != '0);
  assign push               = vld_interface2user && ack_user2interface;
  assign pop                = rd_en && empty_n;
  assign dout               = mem[rd_ptr];

  always_ff @(posedge clk_user) begin
    if (push) begin
      mem[wr_ptr] <= dout_leaf_interface2user;
    end
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef LEAF_USER_IN_FIFO_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // word_cnt wraps naturally; stall_cnt sticks at all-ones.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (vld_interface2user && !ack_user2interface) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Directed bench for leaf_user_in_fifo: fill, drain, full/pop, streaming, mid-stream reset, empty reads.
module tb_leaf_user_in_fifo;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        vld;
  logic        ack;
  logic [31:0] dout;
  logic        empty_n;
  logic        rd_en;
  logic [4:0]  count;
`ifdef LEAF_USER_IN_FIFO_STATS_EN
  logic [31:0] word_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  leaf_user_in_fifo #(.PAYLOAD_BITS(32), .DEPTH_BITS(4)) dut (
    .clk_user                 (clk_user),
    .reset                    (reset),
    .dout_leaf_interface2user (din),
    .vld_interface2user       (vld),
    .ack_user2interface       (ack),
    .dout                     (dout),
    .empty_n                  (empty_n),
    .rd_en                    (rd_en),
`ifdef LEAF_USER_IN_FIFO_STATS_EN
    .word_cnt                 (word_cnt),
    .stall_cnt                (stall_cnt),
`endif
    .count                    (count)
  );

  always #5 clk_user = ~clk_user;

  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = '0;
    vld   = 1'b0;
    rd_en = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Test 1: reset state, push 1..5, then drain in order.
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty_n", 32'(empty_n), 32'd0);
    check("rst_ack", 32'(ack), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      vld = 1'b1;
      din = 32'(i);
      check("t1_ack", 32'(ack), 32'd1);
      step();
      check("t1_empty_n", 32'(empty_n), 32'd1);
      check("t1_count", 32'(count), 32'(i));
    end
    vld = 1'b0;
    rd_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("t1_dout", dout, 32'(i));
      check("t1_rd_empty_n", 32'(empty_n), 32'd1);
      step();
    end
    rd_en = 1'b0;
    check("t1_drained_empty_n", 32'(empty_n), 32'd0);
    check("t1_drained_count", 32'(count), 32'd0);

    // Test 2: 20 cycles of vld with no reads; only 16 accepted.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      vld = 1'b1;
      din = 32'(c);
      check("t2_ack", 32'(ack), (c < 16) ? 32'd1 : 32'd0);
      step();
    end
    vld = 1'b0;
    check("t2_count", 32'(count), 32'd16);
    check("t2_ack_full", 32'(ack), 32'd0);
`ifdef LEAF_USER_IN_FIFO_STATS_EN
    check("t2_word_cnt", word_cnt, 32'd16);
    check("t2_stall_cnt", stall_cnt, 32'd4);
`endif

    // Test 3: pop at full with a pending word; push lands one cycle later.
    vld   = 1'b1;
    din   = 32'h100;
    rd_en = 1'b1;
    check("t3_ack_full", 32'(ack), 32'd0);
    check("t3_head", dout, 32'd0);
    step();
    rd_en = 1'b0;
    check("t3_count_15", 32'(count), 32'd15);
    check("t3_ack_back", 32'(ack), 32'd1);
    check("t3_head2", dout, 32'd1);
    step();
    vld = 1'b0;
    check("t3_count_16", 32'(count), 32'd16);
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("t3_drain", dout, (i == 16) ? 32'h100 : 32'(i));
      step();
    end
    rd_en = 1'b0;
    check("t3_drained", 32'(empty_n), 32'd0);

    // Test 4: 100 words streamed with simultaneous push and pop.
    for (int i = 0; i < 100; i++) begin
      vld   = 1'b1;
      rd_en = 1'b1;
      din   = 32'(i);
      if (i > 0) begin
        check("t4_dout", dout, 32'(i - 1));
        check("t4_empty_n", 32'(empty_n), 32'd1);
      end
      check("t4_count_le1", 32'(count <= 5'd1), 32'd1);
      step();
    end
    vld = 1'b0;
    check("t4_last", dout, 32'd99);
    step();
    rd_en = 1'b0;
    check("t4_empty_after", 32'(empty_n), 32'd0);

    // Test 5: reset with 7 words buffered and a word still being offered.
    for (int i = 0; i < 7; i++) begin
      vld = 1'b1;
      din = 32'h10 + 32'(i);
      step();
    end
    check("t5_count7", 32'(count), 32'd7);
    din   = 32'h17;
    reset = 1'b1;
    step();
    reset = 1'b0;
    vld   = 1'b0;
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_empty_n", 32'(empty_n), 32'd0);
    check("t5_rst_ack", 32'(ack), 32'd1);
    vld = 1'b1;
    din = 32'hA5A5_A5A5;
    step();
    vld = 1'b0;
    check("t5_new_empty_n", 32'(empty_n), 32'd1);
    check("t5_new_dout", dout, 32'hA5A5_A5A5);
    check("t5_new_count", 32'(count), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t5_popped", 32'(empty_n), 32'd0);

    // Test 6: reads while empty are ignored.
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_count", 32'(count), 32'd0);
      check("t6_empty_n", 32'(empty_n), 32'd0);
    end
    rd_en = 1'b0;
    vld = 1'b1;
    din = 32'h5A5A_0001;
    step();
    vld = 1'b0;
    check("t6_dout", dout, 32'h5A5A_0001);
    check("t6_count1", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
